// File: rtl/v810_wbuf.sv
`default_nettype none
// ============================================================================
// Module   : v810_wbuf
// Purpose  : Posted-write buffer between the execution unit and the bus MUX.
//            A circular FIFO of DEPTH write entries. It accepts pushes from
//            the EU, presents the oldest entry to the bus for draining, and
//            answers a pending-read hazard probe against all queued stores.
// Config   : Define V810_WBUF_FWD_EN to compile in store-to-load forwarding
//            from the youngest matching slot. Without the macro, RFWD and
//            RFWD_D are tied to 0, and the bus MUX stalls reads while RHIT=1.
// Ports    : CLK, RESn (synchronous, active-low), CE (global clock enable)
//            WA/WD/WBC/WBE/WMRQ/WST, WREQ -> WACK     : push side
//            DA/DD/DBC/DBE/DMRQ/DST, DREQ <- DACK     : drain side (head)
//            RCHK/RA/RBE -> RHIT/RFWD/RFWD_D          : read hazard probe
//            FULL/EMPTY/COUNT                         : occupancy
// Revision : 1.0 - initial release
// ============================================================================
module v810_wbuf #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          CLK,
    input  logic          RESn,
    input  logic          CE,
    // push side
    input  logic [31:0]   WA,
    input  logic [31:0]   WD,
    input  logic [1:0]    WBC,
    input  logic [3:0]    WBE,
    input  logic          WMRQ,
    input  logic [1:0]    WST,
    input  logic          WREQ,
    output logic          WACK,
    // drain side
    output logic [31:0]   DA,
    output logic [31:0]   DD,
    output logic [1:0]    DBC,
    output logic [3:0]    DBE,
    output logic          DMRQ,
    output logic [1:0]    DST,
    output logic          DREQ,
    input  logic          DACK,
    // read hazard probe
    input  logic          RCHK,
    input  logic [31:0]   RA,
    input  logic [3:0]    RBE,
    output logic          RHIT,
    output logic          RFWD,
    output logic [31:0]   RFWD_D,
    // occupancy
    output logic          FULL,
    output logic          EMPTY,
    output logic [CW-1:0] COUNT
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // ------------------------------------------------------------------
    // Slot storage (not reset: contents are only meaningful while valid)
    // ------------------------------------------------------------------
    logic [31:0] r_a   [DEPTH];
    logic [31:0] r_d   [DEPTH];
    logic [1:0]  r_bc  [DEPTH];
    logic [3:0]  r_be  [DEPTH];
    logic        r_mrq [DEPTH];
    logic [1:0]  r_st  [DEPTH];

    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);

    // FULL is judged on the registered count, so a same-cycle pop never
    // frees room for a push; reset holds off any acknowledge.
    assign w_push = WREQ & ~w_full & RESn;
    // DACK against an empty buffer is ignored.
    assign w_pop  = DACK & ~w_empty & RESn;

    assign WACK  = w_push;
    assign DREQ  = ~w_empty;
    assign FULL  = w_full;
    assign EMPTY = w_empty;
    assign COUNT = r_count;

    // Head entry goes straight to the bus; a fresh push into an empty
    // buffer only shows up after the edge that stores it.
    assign DA   = r_a[r_rptr];
    assign DD   = r_d[r_rptr];
    assign DBC  = r_bc[r_rptr];
    assign DBE  = r_be[r_rptr];
    assign DMRQ = r_mrq[r_rptr];
    assign DST  = r_st[r_rptr];

    // ------------------------------------------------------------------
    // Pointers and occupancy
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (CE) begin
            if (!RESn) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) r_wptr <= r_wptr + PW'(1);
                if (w_pop)  r_rptr <= r_rptr + PW'(1);
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (CE && w_push) begin
            r_a[r_wptr]   <= WA;
            r_d[r_wptr]   <= WD;
            r_bc[r_wptr]  <= WBC;
            r_be[r_wptr]  <= WBE;
            r_mrq[r_wptr] <= WMRQ;
            r_st[r_wptr]  <= WST;
        end
    end

    // ------------------------------------------------------------------
    // Read hazard probe over the currently valid slots.
    // Slots are walked oldest (k=0 at the read pointer) to youngest, so the
    // last hit seen is the one nearest the write pointer.
    // ------------------------------------------------------------------
    logic w_hit;
`ifdef V810_WBUF_FWD_EN
    logic [PW-1:0] w_yidx;
`endif

    always_comb begin
        w_hit = 1'b0;
`ifdef V810_WBUF_FWD_EN
        w_yidx = '0;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            if ((CW'(k) < r_count) &&
                (r_a[r_rptr + PW'(k)][31:2] == RA[31:2]) &&
                r_mrq[r_rptr + PW'(k)] &&
                ((r_be[r_rptr + PW'(k)] & RBE) != 4'h0)) begin
                w_hit = 1'b1;
`ifdef V810_WBUF_FWD_EN
                w_yidx = r_rptr + PW'(k);
`endif
            end
        end
    end

    assign RHIT = RCHK & w_hit;

`ifdef V810_WBUF_FWD_EN
    // Forward only when the youngest matching store covers every requested
    // byte; a partial cover leaves the read to stall on RHIT.
    assign RFWD   = RHIT & ((r_be[w_yidx] & RBE) == RBE);
    assign RFWD_D = RFWD ? r_d[w_yidx] : 32'h0;
`else
    assign RFWD   = 1'b0;
    assign RFWD_D = 32'h0;
`endif

    // Byte lanes within a word are resolved by RBE, not by RA[1:0].
    logic w_unused_ra;
    assign w_unused_ra = ^RA[1:0];

endmodule
`default_nettype wire
